// File: rtl/shift_add_mult.sv
// ============================================================================
// Module      : shift_add_mult
// Description : Sequential shift-and-add unsigned multiplier, one partial
//               product per clock, W cycles per operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mult #(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2*W-1:0]   r_mcand;
    logic [W-1:0]     r_mplier;
    logic [2*W-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic [2*W-1:0]   r_p;
    logic             r_done;
    logic [2*W-1:0]   w_acc_next;
    logic             w_last;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last     = (r_cnt == CW'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{W{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= CW'(W);
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    // Final iteration publishes the sum including this cycle's add.
                    if (w_last) begin
                        r_p    <= w_acc_next;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign p    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult.sv
// ============================================================================
// Module      : tb_shift_add_mult
// Description : Scoreboard bench for shift_add_mult at W=2, 4 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_mult;

    typedef struct {
        int          inst;
        int unsigned p;
        int          due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s2 = 1'b0, s4 = 1'b0, s8 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy2, busy4, busy8, done2, done4, done8;
    logic [3:0]  p2;
    logic [7:0]  p4;
    logic [15:0] p8;

    int          edges = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    int          last_e[3] = '{-100, -100, -100};
    logic [31:0] last_p[3] = '{32'd0, 32'd0, 32'd0};

    shift_add_mult #(.W(2)) u_dut2 (.clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2),
                                    .busy(busy2), .done(done2), .p(p2));
    shift_add_mult #(.W(4)) u_dut4 (.clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4),
                                    .busy(busy4), .done(done4), .p(p4));
    shift_add_mult #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
                                    .busy(busy8), .done(done8), .p(p8));

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    // Reference: a start accepted at edge E is busy after E..E+W-1, and the
    // product appears with done right after edge E+W; p otherwise holds.
    task automatic mon(input int k, input logic d, input logic bz, input logic [31:0] pv);
        int          w = 2 << k;
        int          idx = -1;
        logic        exp_busy;
        logic        exp_done;
        logic [31:0] exp_p;
        foreach (sb[i]) if (idx < 0 && sb[i].inst == k) idx = i;
        exp_busy = (edges >= last_e[k]) && (edges < last_e[k] + w);
        exp_done = (idx >= 0) && (sb[idx].due <= edges);
        exp_p    = exp_done ? 32'(sb[idx].p) : last_p[k];
        n_cmp++;
        if (bz !== exp_busy) begin
            n_bad++;
            $display("FAIL busy W=%0d edge=%0d got=%b want=%b", w, edges, bz, exp_busy);
        end
        n_cmp++;
        if (d !== exp_done) begin
            n_bad++;
            $display("FAIL done W=%0d edge=%0d got=%b want=%b", w, edges, d, exp_done);
        end
        n_cmp++;
        if (pv !== exp_p) begin
            n_bad++;
            $display("FAIL p W=%0d edge=%0d got=%0d want=%0d", w, edges, pv, exp_p);
        end
        if (exp_done) begin
            last_p[k] = exp_p;
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        mon(0, done2, busy2, 32'(p2));
        mon(1, done4, busy4, 32'(p4));
        mon(2, done8, busy8, 32'(p8));
    end

    // Drives one instance for the coming edge, then returns at the next negedge.
    task automatic step(input int k, input bit s, input int unsigned av,
                        input int unsigned bv, output bit acc);
        int          w = 2 << k;
        int unsigned am = av & ((32'd1 << w) - 1);
        int unsigned bm = bv & ((32'd1 << w) - 1);
        s2 = 1'b0; s4 = 1'b0; s8 = 1'b0;
        case (k)
            0:       begin s2 = s; a2 = am[1:0]; b2 = bm[1:0]; end
            1:       begin s4 = s; a4 = am[3:0]; b4 = bm[3:0]; end
            default: begin s8 = s; a8 = am[7:0]; b8 = bm[7:0]; end
        endcase
        acc = s && !rst && (edges + 1 > last_e[k] + w);
        if (acc) begin
            sb.push_back('{k, am * bm, edges + 1 + w});
            last_e[k] = edges + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(0, 1'b0, 0, 0, acc);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        s2 = 1'b0; s4 = 1'b0; s8 = 1'b0;
        @(posedge clk);
        sb.delete();
        last_e = '{-100, -100, -100};
        last_p = '{32'd0, 32'd0, 32'd0};
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_one(input int k, input int unsigned av, input int unsigned bv);
        bit acc;
        int tries = 0;
        do begin
            step(k, 1'b1, av, bv, acc);
            tries++;
        end while (!acc && tries < 40);
        step(k, 1'b0, av, bv, acc);
    endtask

    initial begin
        bit acc;
        do_reset(2);
        idle(2);

        // Directed W=2 products, including zero operand.
        run_one(0, 3, 3); idle(3);
        run_one(0, 2, 3); idle(3);
        run_one(0, 0, 3); idle(3);

        // All 16 pairs with start held high between them.
        for (int i = 0; i < 16; i++) begin
            int tries = 0;
            do begin
                step(0, 1'b1, i / 4, i % 4, acc);
                tries++;
            end while (!acc && tries < 10);
        end
        idle(4);

        // Start during RUN is ignored.
        step(0, 1'b1, 1, 1, acc);
        step(0, 1'b1, 3, 2, acc);
        idle(4);

        // Reset one edge after a start aborts the operation.
        step(0, 1'b1, 3, 2, acc);
        do_reset(1);
        run_one(0, 2, 2); idle(4);

        // Wider instances at their maximum operands, then p holds.
        run_one(1, 15, 15); idle(6);
        run_one(2, 255, 255); idle(20);

        // Randomized traffic on each width.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 150; n++)
                step(k, ($urandom_range(0, 2) != 0), $urandom, $urandom, acc);
            idle(12);
        end

        idle(4);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d outstanding want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
